// File: rtl/fetch_pkg.sv
// Shared types and defaults for the pipelined fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned ILEN_DEF = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Queue entry at the default widths; the fetch unit uses the same layout
  // at its own parameterised widths.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
    logic                fault;
  } fetch_entry_t;

  // Packed width of a {pc, instr, fault} entry.
  function automatic int unsigned entry_width(input int unsigned xlen,
                                              input int unsigned ilen);
    return xlen + ilen + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched entries; flush empties it and may load
// one entry in the same cycle.
module fetch_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;
  logic [AW-1:0]    wr_idx;

  // Pop only when non-empty; push only when space exists (or a pop frees it).
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count != FULL) || pop_ok);
    wr_idx  = flush ? '0 : wr_ptr;
  end

  // Pointer and count state; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Flush wins over pop; a simultaneous push lands in slot 0.
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if ((flush && push) || (!flush && push_ok)) begin
      mem[wr_idx] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/pipelined_fetch_unit.sv
// Instruction fetch front end: PC generation, epoch-tagged single in-flight
// request, redirect handling and a decode-facing fetch queue.
module pipelined_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter int unsigned      ILEN     = ILEN_DEF,
  parameter int unsigned      QDEPTH   = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_base,
  input  logic [XLEN-1:0]            redirect_offset,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [ILEN-1:0]            imem_resp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_instr,
  output logic                       out_fault,
  output logic [$clog2(QDEPTH):0]    occupancy
);

  localparam int unsigned OCC_W = $clog2(QDEPTH) + 1;
  localparam int unsigned SUM_W = OCC_W + 1;
  localparam int unsigned EW    = entry_width(XLEN, ILEN);
  localparam logic [SUM_W-1:0] QD_LIMIT = SUM_W'(QDEPTH);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(ILEN / 8);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            fault;
  } entry_t;

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] fetch_pc;
  logic            epoch;
  logic            inflight;
  logic            inflight_epoch;
  logic [XLEN-1:0] inflight_pc;

  logic [XLEN-1:0] target;
  logic            target_aligned;
  logic [SUM_W-1:0] pending;
  logic            issue;
  logic            resp_ok;

  logic            q_flush;
  logic            q_push;
  logic            q_pop;
  entry_t          q_data;
  entry_t          head;
  logic [OCC_W-1:0] q_occ;

  // Redirect target, issue decision and response acceptance.
  always_comb begin
    target         = redirect_base + redirect_offset;
    target_aligned = (target[1:0] == 2'b00);
    pending        = {1'b0, q_occ} + SUM_W'(inflight);
    issue          = rst && (state == RUN) && (pending < QD_LIMIT) && !redirect_valid;
    resp_ok        = imem_resp_valid && inflight && (inflight_epoch == epoch);
  end

  // Next state: any redirect decides RUN vs HALT by target alignment.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = target_aligned ? RUN : HALT;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // Queue control: a redirect flushes and optionally loads a fault entry,
  // overriding any same-cycle response or pop.
  always_comb begin
    q_flush = redirect_valid;
    q_push  = 1'b0;
    q_pop   = out_valid && out_ready && !redirect_valid;
    q_data  = '0;
    if (redirect_valid) begin
      q_push       = !target_aligned;
      q_data.pc    = target;
      q_data.instr = '0;
      q_data.fault = 1'b1;
    end else if (resp_ok) begin
      q_push       = 1'b1;
      q_data.pc    = inflight_pc;
      q_data.instr = imem_resp_data;
      q_data.fault = 1'b0;
    end
  end

  // Fetch PC, epoch and in-flight tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc       <= RESET_PC;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_epoch <= epoch;
        inflight_pc    <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= target;
        epoch    <= ~epoch;
      end else if (issue) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (q_flush),
    .push      (q_push),
    .push_data (q_data),
    .pop       (q_pop),
    .head_data (head),
    .occupancy (q_occ)
  );

  assign imem_req_valid = issue;
  assign imem_req_addr  = fetch_pc;
  assign occupancy      = q_occ;
  assign out_valid      = (q_occ != '0);
  // Head fields read as zero whenever the queue is empty.
  assign out_pc         = out_valid ? head.pc    : '0;
  assign out_instr      = out_valid ? head.instr : '0;
  assign out_fault      = out_valid ? head.fault : 1'b0;

endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Directed bench for pipelined_fetch_unit with a one-cycle memory model and
// an expected-entry scoreboard checked on every pop.
module tb_pipelined_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned QDEPTH = 4;

  logic            clk;
  logic            rst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_base;
  logic [XLEN-1:0] redirect_offset;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic            out_fault;
  logic [$clog2(QDEPTH):0] occupancy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  fetch_entry_t sb[$];

  pipelined_fetch_unit #(
    .XLEN     (XLEN),
    .ILEN     (ILEN),
    .QDEPTH   (QDEPTH),
    .RESET_PC (64'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_base   (redirect_base),
    .redirect_offset (redirect_offset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_fault       (out_fault),
    .occupancy       (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ILEN-1:0] mdata(input logic [XLEN-1:0] a);
    return 32'h0000_0013 ^ {a[23:0], 8'h00};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [XLEN-1:0] base, input logic [XLEN-1:0] off);
    redirect_valid  = 1'b1;
    redirect_base   = base;
    redirect_offset = off;
    sb.delete();
  endtask

  // Memory model and scoreboard: on each falling edge compare any pop against
  // the oldest expectation, then record a request about to issue; its data is
  // returned one cycle after the issuing edge.
  initial begin
    logic            v;
    logic [XLEN-1:0] a;
    fetch_entry_t    e;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready && !redirect_valid) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL sb_underflow observed_pc=%h expected=entry", out_pc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pop_pc", out_pc, e.pc);
          check("pop_instr", 64'(out_instr), 64'(e.instr));
          check("pop_fault", 64'(out_fault), 64'(e.fault));
        end
      end
      v = imem_req_valid;
      a = imem_req_addr;
      if (v) begin
        e.pc    = a;
        e.instr = mdata(a);
        e.fault = 1'b0;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      imem_resp_valid = v;
      imem_resp_data  = v ? mdata(a) : 32'hDEAD_BEEF;
    end
  end

  initial begin
    int unsigned reqs;
    logic        found;
    logic [XLEN-1:0] first_addr;

    rst             = 1'b0;
    redirect_valid  = 1'b0;
    redirect_base   = '0;
    redirect_offset = '0;
    out_ready       = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_fault", 64'(out_fault), 64'd0);
    step(); step();
    check("rst_hold_req", 64'(imem_req_valid), 64'd0);

    // Streaming fetch from reset
    rst = 1'b1;
    #1;
    check("s036_req0_valid", 64'(imem_req_valid), 64'd1);
    check("s036_req0_addr", imem_req_addr, 64'h0);
    step();
    check("s036_req1_addr", imem_req_addr, 64'h4);
    check("s036_early_valid", 64'(out_valid), 64'd0);
    step();
    check("s036_out_valid", 64'(out_valid), 64'd1);
    check("s036_out_pc", out_pc, 64'h0);
    check("s036_out_instr", 64'(out_instr), 64'h13);
    repeat (6) step();

    // Backpressure fills the queue
    rst = 1'b0; sb.delete(); out_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    reqs = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      #1;
      if (imem_req_valid) begin
        check("s037_addr", imem_req_addr, 64'(reqs * 4));
        reqs++;
      end
      if (out_valid) check("s037_head_stable", out_pc, 64'h0);
      step();
    end
    check("s037_req_count", 64'(reqs), 64'd4);
    check("s037_occ_full", 64'(occupancy), 64'd4);
    check("s037_blocked", 64'(imem_req_valid), 64'd0);
    out_ready = 1'b1;
    found = 1'b0;
    first_addr = '0;
    for (int unsigned n = 0; n < 5 && !found; n++) begin
      step();
      if (imem_req_valid) begin
        found = 1'b1;
        first_addr = imem_req_addr;
      end
    end
    check("s037_resume_seen", 64'(found), 64'd1);
    check("s037_resume_addr", first_addr, 64'h10);
    repeat (4) step();

    // Redirect coinciding with a response that must be dropped
    rst = 1'b0; sb.delete(); out_ready = 1'b0;
    step();
    rst = 1'b1;
    step(); step(); step();
    check("s038_occ_before", 64'(occupancy), 64'd2);
    #1;
    redirect(64'h100, 64'h20);
    #1;
    check("s038_no_issue", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("s038_occ_after", 64'(occupancy), 64'd0);
    check("s038_empty", 64'(out_valid), 64'd0);
    check("s038_req_valid", 64'(imem_req_valid), 64'd1);
    check("s038_req_addr", imem_req_addr, 64'h120);
    out_ready = 1'b1;
    repeat (5) step();

    // Misaligned redirect halts behind a fault entry
    out_ready = 1'b0;
    redirect(64'h100, 64'h2);
    sb.push_back('{pc: 64'h102, instr: 32'h0, fault: 1'b1});
    #1;
    check("s039_no_issue", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("s039_valid", 64'(out_valid), 64'd1);
    check("s039_pc", out_pc, 64'h102);
    check("s039_instr", 64'(out_instr), 64'd0);
    check("s039_fault", 64'(out_fault), 64'd1);
    check("s039_occ", 64'(occupancy), 64'd1);
    step(); step();
    check("s039_halt_req", 64'(imem_req_valid), 64'd0);
    check("s039_head_stable", out_pc, 64'h102);
    out_ready = 1'b1;
    step();
    check("s039_drained", 64'(occupancy), 64'd0);
    step();
    check("s039_halt_req2", 64'(imem_req_valid), 64'd0);
    redirect(64'h200, 64'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("s039_resume_valid", 64'(imem_req_valid), 64'd1);
    check("s039_resume_addr", imem_req_addr, 64'h200);
    repeat (3) step();

    // Offset arithmetic: negative offset and wrap at 2^XLEN
    redirect(64'h10, 64'hFFFF_FFFF_FFFF_FFF0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("s041_neg_addr", imem_req_addr, 64'h0);
    step();
    redirect(64'hFFFF_FFFF_FFFF_FFFC, 64'h8);
    step();
    redirect_valid = 1'b0;
    #1;
    check("s041_wrap_addr", imem_req_addr, 64'h4);
    repeat (3) step();

    // Reset mid-operation with queued and in-flight data
    rst = 1'b0; sb.delete(); out_ready = 1'b0;
    step();
    rst = 1'b1;
    step(); step(); step(); step();
    check("s040_occ_before", 64'(occupancy), 64'd3);
    rst = 1'b0;
    sb.delete();
    #1;
    check("s040_valid_rst", 64'(out_valid), 64'd0);
    check("s040_occ_rst", 64'(occupancy), 64'd0);
    check("s040_req_rst", 64'(imem_req_valid), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    check("s040_restart_addr", imem_req_addr, 64'h0);
    check("s040_restart_valid", 64'(imem_req_valid), 64'd1);
    step();
    check("s040_stale_dropped", 64'(occupancy), 64'd0);
    step();
    check("s040_first_valid", 64'(out_valid), 64'd1);
    check("s040_first_pc", out_pc, 64'h0);
    out_ready = 1'b1;
    repeat (4) step();

    // Final halt and drain so every expectation has been consumed
    redirect(64'h0, 64'h1);
    sb.push_back('{pc: 64'h1, instr: 32'h0, fault: 1'b1});
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    check("end_sb_drained", 64'(sb.size()), 64'd0);
    check("end_occ", 64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_fetch_unit.md
PIPELINED_FETCH_UNIT -- requirements
Module: pipelined_fetch_unit

Interface
REQ-001 Parameter XLEN, default 64, sets the PC and target address width.
REQ-002 Parameter ILEN, default 32, sets the instruction width.
REQ-003 Parameter QDEPTH, default 4, sets the fetch-queue depth; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, sets the first fetch address after reset.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock; every state change happens on the rising edge.
REQ-007 rst  in  1  asynchronous reset, active-low.
REQ-008 redirect_valid  in  1  one-cycle pulse from branch resolution: take a new fetch target.
REQ-009 redirect_base  in  XLEN  PC of the resolved branch.
REQ-010 redirect_offset  in  XLEN  signed byte offset; target = redirect_base + redirect_offset, modulo 2^XLEN.
REQ-011 imem_req_valid  out  1  fetch request to instruction memory.
REQ-012 imem_req_addr  out  XLEN  byte address of the request.
REQ-013 imem_resp_valid  in  1  response strobe; memory returns data exactly one cycle after the request.
REQ-014 imem_resp_data  in  ILEN  instruction word for that request.
REQ-015 out_valid  out  1  queue head valid toward decode.
REQ-016 out_ready  in  1  decode accepts the head.
REQ-017 out_pc  out  XLEN  PC of the head entry.
REQ-018 out_instr  out  ILEN  instruction of the head entry.
REQ-019 out_fault  out  1  head entry is a misaligned-target fault; out_instr is 0 for a fault entry.
REQ-020 occupancy  out  clog2(QDEPTH)+1  number of valid queue entries.

Function
REQ-021 Issue rule: imem_req_valid = 1 only when all of these hold: state RUN, occupancy + inflight < QDEPTH, and no redirect_valid this cycle.
- imem_req_addr = fetch_pc.
- fetch_pc advances by ILEN/8 on every issued request.
REQ-022 inflight is a 1-bit flag: set on an issued request, cleared the next cycle. It is tagged with the epoch current at issue.
REQ-023 Response handling: when imem_resp_valid = 1 and the inflight tag equals the current epoch, {pc, imem_resp_data, fault = 0} is pushed to the queue tail. Otherwise the response is dropped.
REQ-024 Handshake:
- Pop occurs when out_valid & out_ready.
- out_valid = (occupancy != 0).
- Head fields stay stable while out_valid = 1 and out_ready = 0.
REQ-025 Push and pop in the same cycle on a non-empty queue leave occupancy unchanged. A push to an empty queue is visible at the head the next cycle (one-cycle response-to-output latency).
REQ-026 Redirect in RUN, target word-aligned (target[1:0] == 0):
- Queue is flushed.
- Epoch toggles.
- fetch_pc = target.
- First request to the target issues the next cycle.
REQ-027 Redirect with a misaligned target:
- Queue is flushed and epoch toggles.
- One entry {pc = target, instr = 0, fault = 1} is pushed.
- State moves to HALT.
REQ-028 HALT: no requests issue. Only a later aligned redirect returns the state to RUN, per REQ-026. A further misaligned redirect behaves per REQ-027.
REQ-029 Redirect has priority over a same-cycle pop, response, or issue. The pop is ignored and occupancy after the redirect is 0, or 1 for a fault entry.
REQ-030 A full queue (occupancy == QDEPTH) blocks issue. The queue never overflows, and a response is never dropped for lack of space.
REQ-031 Queue pointers wrap modulo QDEPTH. Full and empty are distinguished by occupancy.

Reset
REQ-032 While rst = 0, the following hold:
- fetch_pc = RESET_PC
- state RUN
- epoch 0
- inflight 0
- occupancy 0
- out_valid = 0
- imem_req_valid = 0
- out_pc = 0, out_instr = 0, out_fault = 0
REQ-033 The first request (addr RESET_PC) issues in the first clk edge cycle after rst rises. A reset asserted mid-operation discards all queued and in-flight data immediately.

Structure
REQ-034 Shared package fetch_pkg holds:
- defaults for XLEN and ILEN
- state enum {RUN, HALT}
- queue entry type {pc, instr, fault}
REQ-035 Sub-module fetch_queue (synchronous FIFO with parameters WIDTH and DEPTH, flush input, occupancy output) holds the entries. pipelined_fetch_unit holds the PC, epoch, inflight flag and state machine.

Verification
REQ-036 Reset release, out_ready = 1, memory returns 0x00000013 → requests at 0, 4, 8, ...; out_valid first rises 2 cycles after the first request, with out_pc = 0.
REQ-037 out_ready = 0 with QDEPTH = 4 → exactly 4 requests (0x0 to 0xC) issue, then occupancy = 4 and imem_req_valid stays 0. Raising out_ready resumes issue at 0x10.
REQ-038 Redirect base 0x100, offset 0x20, in the same cycle a response for 0x8 arrives → 0x8 is dropped, queue empties, and the next request is 0x120.
REQ-039 Redirect base 0x100, offset 0x2 → one entry {0x102, 0, fault = 1}, then no requests. A later redirect base 0x200, offset 0 → requests resume at 0x200.
REQ-040 Reset asserted with 3 entries queued and a request in flight → out_valid = 0 and occupancy = 0 immediately. After release, fetch restarts at RESET_PC and no stale response appears.
REQ-041 Redirect base 0x10, offset −0x10 (all ones above bit 4) → target 0x0. Wrap of offset arithmetic checked at 2^XLEN − 4 + 8 = 0x4.
